alu4_result_stage: RTL

ALU4_RESULT_STAGE -- requirements
Module: alu4_result_stage

---
 rtl/alu4_pkg.sv | 20 ++
 rtl/alu4_flag_gen.sv | 25 ++
 rtl/alu4_result_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - opcodes, flag bit positions and buffer entry type for the ALU4 result stage
package alu4_pkg;

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  // Flag positions inside the {P,N,C,Z} nibble, MSB first
  localparam int FLAG_P = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] flags;
  } entry_t;

endpackage

// File: rtl/alu4_flag_gen.sv
// rtl/alu4_flag_gen.sv - combinational N/C/Z flags, plus P when ALU4_PARITY_EN is defined
module alu4_flag_gen
  import alu4_pkg::*;
(
  input  logic [3:0] res,
  input  logic       cout,
  input  logic [1:0] op,
`ifdef ALU4_PARITY_EN
  output logic       p,
`endif
  output logic [2:0] nzc
);

  always_comb begin
    nzc         = '0;
    nzc[FLAG_N] = res[3];
    nzc[FLAG_C] = (op == OP_ADD) ? cout : 1'b0;
    nzc[FLAG_Z] = (res == 4'b0000);
  end

`ifdef ALU4_PARITY_EN
  assign p = ^res;
`endif

endmodule

// File: rtl/alu4_result_stage.sv
// rtl/alu4_result_stage.sv - DEPTH-entry result buffer storing ALU results with flags
// Optional parity flag storage enabled by macro ALU4_PARITY_EN.
module alu4_result_stage
  import alu4_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_res,
  input  logic       in_cout,
  input  logic [1:0] in_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_res,
  output logic [3:0] out_flags,
  output logic [2:0] count
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
    $error("alu4_result_stage: DEPTH must be 2 or 4");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    res_mem [DEPTH];
  logic [2:0]    nzc_mem [DEPTH];
  logic [2:0]    new_nzc;
  logic          push;
  logic          pop;
  entry_t        head;

`ifdef ALU4_PARITY_EN
  logic          p_mem   [DEPTH];
  logic          new_p;
`endif

  alu4_flag_gen u_flag_gen (
    .res  (in_res),
    .cout (in_cout),
    .op   (in_op),
`ifdef ALU4_PARITY_EN
    .p    (new_p),
`endif
    .nzc  (new_nzc)
  );

  // Handshakes depend only on registered occupancy, so out_ready never reaches in_ready
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != 3'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: the head is masked whenever the buffer is empty
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr] <= in_res;
      nzc_mem[wr_ptr] <= new_nzc;
`ifdef ALU4_PARITY_EN
      p_mem[wr_ptr]   <= new_p;
`endif
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) begin
      head.res   = res_mem[rd_ptr];
`ifdef ALU4_PARITY_EN
      head.flags = {p_mem[rd_ptr], nzc_mem[rd_ptr]};
`else
      head.flags = {1'b0, nzc_mem[rd_ptr]};
`endif
    end
  end

  assign out_res   = head.res;
  assign out_flags = head.flags;

endmodule
